// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Redirect kinds are encoded so that a larger value means higher priority.
package pc_seq_pkg;

    localparam int unsigned PC_W_DEF      = 16;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    // Redirect priority levels (larger wins)
    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_RET  = 2'd1;
    localparam logic [1:0] PRIO_BR   = 2'd2;
    localparam logic [1:0] PRIO_JMP  = 2'd3;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REDIR_NONE = PRIO_NONE,
        REDIR_RET  = PRIO_RET,
        REDIR_BR   = PRIO_BR,
        REDIR_JMP  = PRIO_JMP
    } redir_t;

    // A newer request replaces the held one when it is at least as urgent.
    function automatic logic redir_wins(input redir_t incoming, input redir_t held);
        return (incoming != REDIR_NONE) && (incoming >= held);
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Bus bundle between the next-PC sequencer (master) and its surroundings
// (pc register, instruction memory, execute stage) seen as the slave side.
interface pc_seq_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
);
    logic [PC_W-1:0] pc_cur;
    logic            pcsignal;
    logic [PC_W-1:0] pcin;
    logic            imem_req;
    logic            imem_ack;
    logic            stall;
    logic            jmp;
    logic [PC_W-1:0] jmp_target;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            call;
    logic            ret;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_err;

    modport master (
        input  pc_cur, imem_ack, stall, jmp, jmp_target, br_taken, br_target, call, ret,
        output pcsignal, pcin, imem_req, ras_empty, ras_full, ras_err
    );

    modport slave (
        output pc_cur, imem_ack, stall, jmp, jmp_target, br_taken, br_target, call, ret,
        input  pcsignal, pcin, imem_req, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_seq_ras.sv
// Circular return-address stack. Pushing into a full stack overwrites the
// oldest entry and the stack stays full. Used only when PC_SEQ_RAS_EN is defined.
module pc_seq_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned DEPTH = RAS_DEPTH_DEF
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] mem_r [DEPTH];
    logic [IW-1:0]   wp_r;
    logic [CW-1:0]   cnt_r;
    logic [IW-1:0]   tp_s;
    logic [IW-1:0]   wp_inc_s;

    // Index of the most recent entry and the wrapped next write slot
    always_comb begin
        if (wp_r == {IW{1'b0}}) begin
            tp_s = IW'(DEPTH - 1);
        end else begin
            tp_s = wp_r - IW'(1);
        end
        if (wp_r == IW'(DEPTH - 1)) begin
            wp_inc_s = {IW{1'b0}};
        end else begin
            wp_inc_s = wp_r + IW'(1);
        end
    end

    // Stack storage, write pointer and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {PC_W{1'b0}};
            end
            wp_r  <= {IW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (push) begin
            mem_r[wp_r] <= din;
            wp_r        <= wp_inc_s;
            if (cnt_r != CW'(DEPTH)) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else if (pop && (cnt_r != {CW{1'b0}})) begin
            wp_r  <= tp_s;
            cnt_r <= cnt_r - CW'(1);
        end
    end

    assign top   = mem_r[tp_s];
    assign empty = (cnt_r == {CW{1'b0}});
    assign full  = (cnt_r == CW'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boots from RESET_VEC, handshakes instruction fetches,
// holds on stall and applies jump/branch/call/return redirects at the next load.
// Optional feature macro: PC_SEQ_RAS_EN enables the return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] INC       = {{(PC_W-1){1'b0}}, 1'b1},
    parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
)(
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.master bus
);
`ifdef PC_SEQ_RAS_EN
    localparam logic RAS_ON = 1'b1;
`else
    localparam logic RAS_ON = 1'b0;
`endif

    state_t          state_r;
    redir_t          pend_kind_r;
    logic [PC_W-1:0] pend_tgt_r;
    logic            pcsignal_r;
    logic [PC_W-1:0] pcin_r;
    logic            imem_req_r;
    logic            ras_err_r;

    redir_t          in_kind_s;
    logic [PC_W-1:0] in_tgt_s;
    redir_t          mrg_kind_s;
    logic [PC_W-1:0] mrg_tgt_s;
    logic [PC_W-1:0] seq_pc_s;
    logic [PC_W-1:0] next_pc_s;
    logic            enter_load_s;
    logic            push_s;
    logic            pop_s;
    logic            err_s;
    logic [PC_W-1:0] ras_top_s;
    logic            ras_empty_s;
    logic            ras_full_s;

    assign seq_pc_s     = bus.pc_cur + INC;
    assign push_s       = bus.call & RAS_ON;
    assign enter_load_s = ((state_r == ST_FETCH) && bus.imem_ack && !bus.stall) ||
                          ((state_r == ST_HOLD) && !bus.stall);

    // Decode this cycle's redirect pulses; call acts as a jump to jmp_target
    always_comb begin
        in_kind_s = REDIR_NONE;
        in_tgt_s  = {PC_W{1'b0}};
        if (bus.jmp || bus.call) begin
            in_kind_s = REDIR_JMP;
            in_tgt_s  = bus.jmp_target;
        end else if (bus.br_taken) begin
            in_kind_s = REDIR_BR;
            in_tgt_s  = bus.br_target;
        end else if (bus.ret && RAS_ON) begin
            in_kind_s = REDIR_RET;
        end else begin
            in_kind_s = REDIR_NONE;
        end
    end

    // Merge the incoming pulse with the pending slot by priority
    always_comb begin
        mrg_kind_s = pend_kind_r;
        mrg_tgt_s  = pend_tgt_r;
        if (redir_wins(in_kind_s, pend_kind_r)) begin
            mrg_kind_s = in_kind_s;
            mrg_tgt_s  = in_tgt_s;
        end else begin
            mrg_kind_s = pend_kind_r;
            mrg_tgt_s  = pend_tgt_r;
        end
    end

    // Next-PC mux; a return on an empty stack falls back to sequential
    always_comb begin
        next_pc_s = seq_pc_s;
        pop_s     = 1'b0;
        err_s     = 1'b0;
        case (mrg_kind_s)
            REDIR_JMP, REDIR_BR: next_pc_s = mrg_tgt_s;
            REDIR_RET: begin
                if (!ras_empty_s) begin
                    next_pc_s = ras_top_s;
                    pop_s     = enter_load_s;
                end else begin
                    next_pc_s = seq_pc_s;
                    err_s     = enter_load_s;
                end
            end
            default: next_pc_s = seq_pc_s;
        endcase
    end

    // Pending redirect slot: consumed on entry to LOAD, otherwise accumulates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_kind_r <= REDIR_NONE;
            pend_tgt_r  <= {PC_W{1'b0}};
        end else if (enter_load_s) begin
            pend_kind_r <= REDIR_NONE;
            pend_tgt_r  <= {PC_W{1'b0}};
        end else begin
            pend_kind_r <= mrg_kind_s;
            pend_tgt_r  <= mrg_tgt_s;
        end
    end

    // Sequencer FSM with registered strobe, load value, fetch request and error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_BOOT;
            pcsignal_r <= 1'b0;
            pcin_r     <= RESET_VEC;
            imem_req_r <= 1'b0;
            ras_err_r  <= 1'b0;
        end else begin
            pcsignal_r <= 1'b0;
            ras_err_r  <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    state_r    <= ST_LOAD;
                    pcsignal_r <= 1'b1;
                    pcin_r     <= RESET_VEC;
                    imem_req_r <= 1'b0;
                end
                ST_LOAD: begin
                    state_r    <= ST_FETCH;
                    imem_req_r <= 1'b1;
                end
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        imem_req_r <= 1'b0;
                        if (bus.stall) begin
                            state_r <= ST_HOLD;
                        end else begin
                            state_r    <= ST_LOAD;
                            pcsignal_r <= 1'b1;
                            pcin_r     <= next_pc_s;
                            ras_err_r  <= err_s;
                        end
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    imem_req_r <= 1'b0;
                    if (!bus.stall) begin
                        state_r    <= ST_LOAD;
                        pcsignal_r <= 1'b1;
                        pcin_r     <= next_pc_s;
                        ras_err_r  <= err_s;
                    end
                end
                default: begin
                    state_r    <= ST_BOOT;
                    imem_req_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_RAS_EN
    pc_seq_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (seq_pc_s),
        .top   (ras_top_s),
        .empty (ras_empty_s),
        .full  (ras_full_s)
    );
`else
    logic unused_ras_s;
    assign unused_ras_s = push_s ^ pop_s;
    assign ras_top_s    = {PC_W{1'b0}};
    assign ras_empty_s  = 1'b1;
    assign ras_full_s   = 1'b0;
`endif

    assign bus.pcsignal  = pcsignal_r;
    assign bus.pcin      = pcin_r;
    assign bus.imem_req  = imem_req_r;
    assign bus.ras_err   = ras_err_r;
    assign bus.ras_empty = ras_empty_s;
    assign bus.ras_full  = ras_full_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes the expected load value,
// a negedge monitor pops and compares on every pcsignal strobe.
// Return-stack expectations depend on PC_SEQ_RAS_EN.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] pc_r;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic        prev_strobe;
    int          n_vec;
    int          n_err;
    logic [15:0] ret_exp [4] = '{16'h3301, 16'h3201, 16'h3101, 16'h3001};

    pc_seq_if #(.PC_W(16)) bus ();

    pc_sequencer #(
        .PC_W      (16),
        .RESET_VEC (16'h0000),
        .INC       (16'h0001),
        .RAS_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the pc register fed by the sequencer
    always @(posedge clk) begin
        if (bus.pcsignal === 1'b1) pc_r <= bus.pcin;
    end
    assign bus.pc_cur = pc_r;

    // Monitor: every load strobe must match the oldest expected value
    always @(negedge clk) begin
        if (bus.pcsignal === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_load: pcin=%h with no load expected", bus.pcin);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.pcin !== mon_exp) begin
                    n_err++;
                    $display("FAIL load_value: pcin=%h expected %h", bus.pcin, mon_exp);
                end
            end
            if (prev_strobe === 1'b1) begin
                n_err++;
                $display("FAIL double_strobe: pcsignal=1 expected 0 after a strobe cycle");
            end
        end
        prev_strobe = bus.pcsignal;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 20; i++) begin
            if (bus.imem_req === 1'b1) break;
            step();
        end
        chk("wait_req_timeout", {15'd0, bus.imem_req}, 16'h0001);
    endtask

    task automatic redirect(input logic j, input logic c, input logic b, input logic r,
                            input logic [15:0] jt, input logic [15:0] bt);
        bus.jmp = j; bus.call = c; bus.br_taken = b; bus.ret = r;
        bus.jmp_target = jt; bus.br_target = bt;
        step();
        bus.jmp = 1'b0; bus.call = 1'b0; bus.br_taken = 1'b0; bus.ret = 1'b0;
    endtask

    task automatic fetch(input int stall_n, input logic [15:0] exp, input logic exp_err);
        wait_req();
        exp_q.push_back(exp);
        bus.imem_ack = 1'b1;
        bus.stall    = (stall_n > 0);
        step();
        bus.imem_ack = 1'b0;
        if (stall_n > 0) begin
            for (int i = 1; i < stall_n; i++) begin
                chk("hold_no_strobe", {15'd0, bus.pcsignal}, 16'h0000);
                chk("hold_no_req", {15'd0, bus.imem_req}, 16'h0000);
                step();
            end
            chk("hold_no_strobe", {15'd0, bus.pcsignal}, 16'h0000);
            bus.stall = 1'b0;
            step();
        end
        chk("load_strobe", {15'd0, bus.pcsignal}, 16'h0001);
        chk("ras_err_at_load", {15'd0, bus.ras_err}, {15'd0, exp_err});
        step();
        chk("req_after_load", {15'd0, bus.imem_req}, 16'h0001);
        chk("ras_err_cleared", {15'd0, bus.ras_err}, 16'h0000);
    endtask

    initial begin
        n_vec = 0; n_err = 0; prev_strobe = 1'b0; pc_r = 16'h0000;
        reset = 1'b0;
        bus.imem_ack = 1'b0; bus.stall = 1'b0;
        bus.jmp = 1'b0; bus.call = 1'b0; bus.br_taken = 1'b0; bus.ret = 1'b0;
        bus.jmp_target = 16'h0000; bus.br_target = 16'h0000;
        step(); step();

        // Reset state
        chk("rst_pcsignal", {15'd0, bus.pcsignal}, 16'h0000);
        chk("rst_pcin", bus.pcin, 16'h0000);
        chk("rst_imem_req", {15'd0, bus.imem_req}, 16'h0000);
        chk("rst_ras_empty", {15'd0, bus.ras_empty}, 16'h0001);
        chk("rst_ras_full", {15'd0, bus.ras_full}, 16'h0000);
        chk("rst_ras_err", {15'd0, bus.ras_err}, 16'h0000);

        // Boot: one strobe at RESET_VEC, request on the following cycle
        exp_q.push_back(16'h0000);
        reset = 1'b1;
        step();
        chk("boot_strobe", {15'd0, bus.pcsignal}, 16'h0001);
        chk("boot_no_req", {15'd0, bus.imem_req}, 16'h0000);
        step();
        chk("boot_req", {15'd0, bus.imem_req}, 16'h0001);
        chk("boot_strobe_low", {15'd0, bus.pcsignal}, 16'h0000);

        // Sequential increments and wrap
        redirect(1'b1, 1'b0, 1'b0, 1'b0, 16'h1212, 16'h0000);
        fetch(0, 16'h1212, 1'b0);
        fetch(0, 16'h1213, 1'b0);
        redirect(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        fetch(0, 16'hFFFF, 1'b0);
        fetch(0, 16'h0000, 1'b0);

        // Stall for three cycles
        fetch(3, 16'h0001, 1'b0);
        fetch(0, 16'h0002, 1'b0);

        // Priority: jmp beats br in the same cycle, slot cleared afterwards
        redirect(1'b1, 1'b0, 1'b1, 1'b0, 16'haaaa, 16'h2345);
        fetch(0, 16'haaaa, 1'b0);
        fetch(0, 16'haaab, 1'b0);

        // Branch pulsed two cycles before ack
        redirect(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h2345);
        step();
        fetch(0, 16'h2345, 1'b0);
        fetch(0, 16'h2346, 1'b0);

        // Branch arriving during LOAD stays pending for the next load
        wait_req();
        exp_q.push_back(16'h2347);
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        chk("load_strobe", {15'd0, bus.pcsignal}, 16'h0001);
        redirect(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5555);
        chk("req_after_load", {15'd0, bus.imem_req}, 16'h0001);
        fetch(0, 16'h5555, 1'b0);

        // Jump in the same cycle as ack is merged into this load
        wait_req();
        exp_q.push_back(16'h3000);
        bus.imem_ack = 1'b1;
        redirect(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000);
        bus.imem_ack = 1'b0;
        chk("merge_strobe", {15'd0, bus.pcsignal}, 16'h0001);
        step();

        // Later lower-priority branch does not overwrite a pending jump
        redirect(1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000);
        redirect(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h6000);
        fetch(0, 16'h4000, 1'b0);
        fetch(0, 16'h4001, 1'b0);

        // Call / return
        redirect(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
        fetch(0, 16'h0100, 1'b0);
        redirect(1'b0, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0000);
        fetch(0, 16'h2000, 1'b0);
`ifdef PC_SEQ_RAS_EN
        chk("call_ras_empty", {15'd0, bus.ras_empty}, 16'h0000);
        redirect(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        fetch(0, 16'h0101, 1'b0);
        chk("ret_ras_empty", {15'd0, bus.ras_empty}, 16'h0001);
        redirect(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        fetch(0, 16'h0102, 1'b1);
        for (int k = 0; k < 5; k++) begin
            redirect(1'b0, 1'b1, 1'b0, 1'b0, 16'h3000 + 16'(k) * 16'h0100, 16'h0000);
            fetch(0, 16'h3000 + 16'(k) * 16'h0100, 1'b0);
            if (k >= 3) chk("ras_full", {15'd0, bus.ras_full}, 16'h0001);
            else        chk("ras_not_full", {15'd0, bus.ras_full}, 16'h0000);
        end
        for (int k = 0; k < 4; k++) begin
            redirect(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
            fetch(0, ret_exp[k], 1'b0);
        end
        chk("ras_drained", {15'd0, bus.ras_empty}, 16'h0001);
        redirect(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        fetch(0, 16'h3002, 1'b1);
`else
        redirect(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        fetch(0, 16'h2001, 1'b0);
        chk("noras_empty", {15'd0, bus.ras_empty}, 16'h0001);
        chk("noras_full", {15'd0, bus.ras_full}, 16'h0000);
`endif

        // Reset asserted mid-fetch
        wait_req();
        reset = 1'b0;
        #1;
        chk("midrst_req", {15'd0, bus.imem_req}, 16'h0000);
        chk("midrst_strobe", {15'd0, bus.pcsignal}, 16'h0000);
        chk("midrst_ras_empty", {15'd0, bus.ras_empty}, 16'h0001);
        step();
        exp_q.push_back(16'h0000);
        reset = 1'b1;
        step();
        chk("reboot_strobe", {15'd0, bus.pcsignal}, 16'h0001);
        step();
        chk("reboot_req", {15'd0, bus.imem_req}, 16'h0001);
        step(); step();
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
